// File: rtl/fpa_issue_ctrl.sv
// Issue controller for the 3-stage FP add/sub pipeline: credit-gated request issue,
// in-order tag tracking, response buffering, flush drain and error watchdogs.
module fpa_issue_ctrl #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned RESP_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic             Clk,
  input  logic             Clear,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_opa,
  input  logic [31:0]      req_opb,
  input  logic             req_sub,
  input  logic [1:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,

  output logic             Value_In,
  output logic [31:0]      OpA,
  output logic [31:0]      OpB,
  output logic             Sub_Signal,
  output logic [1:0]       Rm,
  input  logic [31:0]      Result,
  input  logic             Value_Out,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_nan,

  input  logic             flush_req,
  output logic             flush_done,
  output logic             err_orphan,
  output logic             err_timeout
);

  localparam int unsigned PtrW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW:0]  DepthLim   = (CntW + 1)'(RESP_DEPTH);
  localparam logic [WdW-1:0] TimeoutLim = WdW'(TIMEOUT);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     inflight_q, inflight_d;
  logic [CntW-1:0]     resp_cnt_q, resp_cnt_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [1:0]          grace_q, grace_d;

  logic                value_in_q;
  logic [31:0]         opa_q, opb_q;
  logic                sub_q;
  logic [1:0]          rm_q;
  logic                err_orphan_q, err_timeout_q;

  logic [TAG_W-1:0]    tq_mem [RESP_DEPTH];
  logic [PtrW-1:0]     tq_wr_q, tq_rd_q;
  logic [31:0]         rf_res_mem [RESP_DEPTH];
  logic [TAG_W-1:0]    rf_tag_mem [RESP_DEPTH];
  logic [PtrW-1:0]     rf_wr_q, rf_rd_q;

  logic                accept, ret, orphan, pop, credit_ok;

  // Credit covers both queues so a launched op always has a response slot.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, resp_cnt_q}) < DepthLim;
  assign req_ready = Clear && (state_q == StRun) && credit_ok;

  assign accept = req_valid && req_ready;
  assign ret    = Value_Out && (inflight_q != '0);
  // Stale returns from ops launched before reset are dropped silently while grace runs.
  assign orphan = Value_Out && (inflight_q == '0) && (grace_q == '0);
  assign pop    = rsp_valid && rsp_ready;

  assign rsp_valid  = (resp_cnt_q != '0);
  assign rsp_result = rsp_valid ? rf_res_mem[rf_rd_q] : '0;
  assign rsp_tag    = rsp_valid ? rf_tag_mem[rf_rd_q] : '0;
  assign rsp_nan    = (rsp_result[30:23] == 8'hFF) && (rsp_result[22:0] != '0);

  assign Value_In    = value_in_q;
  assign OpA         = opa_q;
  assign OpB         = opb_q;
  assign Sub_Signal  = sub_q;
  assign Rm          = rm_q;
  assign err_orphan  = err_orphan_q;
  assign err_timeout = err_timeout_q;

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    unique case (state_q)
      StRun:   if (flush_req) state_d = StDrain;
      StDrain: if ((inflight_q == '0) && (resp_cnt_q == '0)) state_d = StDone;
      StDone: begin
        flush_done = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q + CntW'(accept) - CntW'(ret);
    resp_cnt_d = resp_cnt_q + CntW'(ret) - CntW'(pop);

    wd_d = wd_q;
    if (Value_Out || (inflight_q == '0)) begin
      wd_d = '0;
    end else if (wd_q != TimeoutLim) begin
      wd_d = wd_q + WdW'(1);
    end

    grace_d = (grace_q != '0) ? grace_q - 2'd1 : grace_q;
  end

  always_ff @(posedge Clk) begin
    if (!Clear) begin
      state_q       <= StRun;
      inflight_q    <= '0;
      resp_cnt_q    <= '0;
      wd_q          <= '0;
      grace_q       <= 2'd3;
      value_in_q    <= 1'b0;
      opa_q         <= '0;
      opb_q         <= '0;
      sub_q         <= 1'b0;
      rm_q          <= '0;
      err_orphan_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      tq_wr_q       <= '0;
      tq_rd_q       <= '0;
      rf_wr_q       <= '0;
      rf_rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      resp_cnt_q <= resp_cnt_d;
      wd_q       <= wd_d;
      grace_q    <= grace_d;
      value_in_q <= accept;
      if (accept) begin
        opa_q   <= req_opa;
        opb_q   <= req_opb;
        sub_q   <= req_sub;
        rm_q    <= req_rm;
        tq_wr_q <= tq_wr_q + PtrW'(1);
      end
      if (ret) begin
        tq_rd_q <= tq_rd_q + PtrW'(1);
        rf_wr_q <= rf_wr_q + PtrW'(1);
      end
      if (pop) begin
        rf_rd_q <= rf_rd_q + PtrW'(1);
      end
      if (orphan) begin
        err_orphan_q <= 1'b1;
      end
      if (wd_d == TimeoutLim) begin
        err_timeout_q <= 1'b1;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge Clk) begin
    if (accept) begin
      tq_mem[tq_wr_q] <= req_tag;
    end
    if (Clear && ret) begin
      rf_res_mem[rf_wr_q] <= Result;
      rf_tag_mem[rf_wr_q] <= tq_mem[tq_rd_q];
    end
  end

endmodule

// File: tb/tb_fpa_issue_ctrl.sv
// Directed bench for fpa_issue_ctrl with a 3-stage stand-in pipeline and Value_Out injection.
module tb_fpa_issue_ctrl;

  localparam int unsigned TagW = 4;

  logic            Clk = 1'b0;
  logic            Clear;
  logic            req_valid, req_ready, req_sub;
  logic [31:0]     req_opa, req_opb;
  logic [1:0]      req_rm;
  logic [TagW-1:0] req_tag;
  logic            Value_In, Sub_Signal, Value_Out;
  logic [31:0]     OpA, OpB, Result;
  logic [1:0]      Rm;
  logic            rsp_valid, rsp_ready, rsp_nan;
  logic [31:0]     rsp_result;
  logic [TagW-1:0] rsp_tag;
  logic            flush_req, flush_done, err_orphan, err_timeout;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 Clk = ~Clk;

  fpa_issue_ctrl #(
    .TAG_W      (TagW),
    .RESP_DEPTH (4),
    .TIMEOUT    (8)
  ) dut (
    .Clk         (Clk),
    .Clear       (Clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_sub     (req_sub),
    .req_rm      (req_rm),
    .req_tag     (req_tag),
    .Value_In    (Value_In),
    .OpA         (OpA),
    .OpB         (OpB),
    .Sub_Signal  (Sub_Signal),
    .Rm          (Rm),
    .Result      (Result),
    .Value_Out   (Value_Out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_tag     (rsp_tag),
    .rsp_nan     (rsp_nan),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .err_orphan  (err_orphan),
    .err_timeout (err_timeout)
  );

  // Stand-in pipeline: known FP vectors give hand-computed sums, others an integer sum.
  logic        pipe_en = 1'b1;
  logic        inj_vo  = 1'b0;
  logic [31:0] inj_res = '0;
  logic [2:0]  pv      = '0;
  logic [31:0] pr0 = '0, pr1 = '0, pr2 = '0;

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    if (!s && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h7FC00000) return 32'h7FC00000;
    return s ? a - b : a + b;
  endfunction

  always @(posedge Clk) begin
    pv  <= {pv[1:0], Value_In & pipe_en};
    pr0 <= fp_model(OpA, OpB, Sub_Signal);
    pr1 <= pr0;
    pr2 <= pr1;
  end

  assign Value_Out = pv[2] | inj_vo;
  assign Result    = inj_vo ? inj_res : pr2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 12) begin
      tick();
      n++;
    end
    check(tag, rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    Clear = 1'b0; req_valid = 0; req_opa = '0; req_opb = '0; req_sub = 0; req_rm = '0;
    req_tag = '0; rsp_ready = 0; flush_req = 0;
    tick();
    tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_value_in", Value_In, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_flags", {err_orphan, err_timeout, flush_done}, 0);
    Clear = 1'b1;
    repeat (4) tick();
    check("idle_req_ready", req_ready, 1);

    // Single add with immediate consumer.
    rsp_ready = 1; req_valid = 1; req_opa = 32'h3F800000; req_opb = 32'h40000000;
    req_sub = 0; req_rm = 2'd2; req_tag = 4'd5;
    tick();
    req_valid = 0;
    check("t1_value_in", Value_In, 1);
    check("t1_opa", OpA, 32'h3F800000);
    check("t1_opb", OpB, 32'h40000000);
    check("t1_sub", Sub_Signal, 0);
    check("t1_rm", Rm, 2'd2);
    tick();
    check("t1_value_in_drop", Value_In, 0);
    wait_rsp("t1_wait");
    check("t1_result", rsp_result, 32'h40400000);
    check("t1_tag", rsp_tag, 5);
    check("t1_nan", rsp_nan, 0);
    tick();
    check("t1_popped", rsp_valid, 0);

    // Four back-to-back with a stalled consumer; fifth must be refused.
    rsp_ready = 0; req_valid = 1; req_opb = 32'h100; req_rm = '0;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(i);
      req_opa = 32'(i);
      check($sformatf("t2_ready%0d", i), req_ready, 1);
      tick();
    end
    req_tag = 4'd4; req_opa = 32'd4;
    check("t2_stall", req_ready, 0);
    repeat (6) tick();
    check("t2_stall_held", req_ready, 0);
    check("t2_rsp_valid", rsp_valid, 1);
    req_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_tag%0d", i), rsp_tag, 64'(i));
      check($sformatf("t2_res%0d", i), rsp_result, 64'(32'h100 + i));
      tick();
    end
    check("t2_empty", rsp_valid, 0);
    rsp_ready = 0;

    // Accept, return and pop in one cycle with one op in flight and one buffered.
    pipe_en = 0; req_valid = 1; req_opa = 32'd1; req_tag = 4'd10;
    tick();
    req_opa = 32'd2; req_tag = 4'd11;
    tick();
    req_valid = 0; inj_vo = 1; inj_res = 32'hAAAA0001;
    tick();
    inj_vo = 0;
    check("t3_head_a", rsp_tag, 10);
    req_valid = 1; req_opa = 32'd3; req_tag = 4'd12;
    inj_vo = 1; inj_res = 32'hBBBB0002; rsp_ready = 1;
    check("t3_ready_before", req_ready, 1);
    tick();
    req_valid = 0; inj_vo = 0; rsp_ready = 0;
    check("t3_head_b_tag", rsp_tag, 11);
    check("t3_head_b_res", rsp_result, 32'hBBBB0002);
    check("t3_ready_after", req_ready, 1);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t3_one_entry", rsp_valid, 0);
    inj_vo = 1; inj_res = 32'hCCCC0003;
    tick();
    inj_vo = 0;
    check("t3_head_c_tag", rsp_tag, 12);
    check("t3_head_c_res", rsp_result, 32'hCCCC0003);
    check("t3_no_orphan", err_orphan, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t3_drained", rsp_valid, 0);

    // NaN result, then a return with nothing in flight.
    pipe_en = 1; req_valid = 1; req_opa = 32'h7FC00000; req_opb = 32'h3F800000; req_tag = 4'd9;
    tick();
    req_valid = 0;
    wait_rsp("t4_wait");
    check("t4_nan", rsp_nan, 1);
    check("t4_result", rsp_result, 32'h7FC00000);
    check("t4_tag", rsp_tag, 9);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    inj_vo = 1; inj_res = 32'h12345678;
    tick();
    inj_vo = 0;
    check("t4_orphan", err_orphan, 1);
    check("t4_no_rsp", rsp_valid, 0);

    // Lost return: watchdog fires TIMEOUT cycles after issue.
    pipe_en = 0; req_valid = 1; req_opa = 32'd7; req_tag = 4'd3;
    tick();
    req_valid = 0;
    repeat (7) tick();
    check("t5_before", err_timeout, 0);
    tick();
    check("t5_timeout", err_timeout, 1);
    inj_vo = 1; inj_res = '0;
    tick();
    inj_vo = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t5_cleanup", rsp_valid, 0);

    // Flush with two in flight.
    pipe_en = 1; req_valid = 1; req_opa = 32'h10; req_opb = 32'h20; req_tag = 4'd1;
    tick();
    req_tag = 4'd2;
    tick();
    req_valid = 0; flush_req = 1;
    tick();
    flush_req = 0;
    check("t6_drain_ready", req_ready, 0);
    repeat (6) tick();
    check("t6_no_done_yet", flush_done, 0);
    check("t6_rsp", rsp_valid, 1);
    check("t6_head_tag", rsp_tag, 1);
    rsp_ready = 1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (flush_done) pulses++;
    end
    check("t6_pulses", 64'(pulses), 1);
    check("t6_ready_back", req_ready, 1);

    // Reset while an op is in the pipe; its late return falls in the grace window.
    req_valid = 1; req_opa = 32'hDEAD0000; req_opb = 32'd1; req_tag = 4'd7;
    tick();
    req_valid = 0; Clear = 0;
    tick();
    check("t7_value_in", Value_In, 0);
    check("t7_opa", OpA, 0);
    check("t7_rsp_valid", rsp_valid, 0);
    check("t7_req_ready", req_ready, 0);
    check("t7_flags", {err_orphan, err_timeout, flush_done}, 0);
    Clear = 1;
    repeat (6) tick();
    check("t7_no_orphan", err_orphan, 0);
    check("t7_no_rsp", rsp_valid, 0);
    check("t7_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
